// File: rtl/user_uart_pkg.sv
// Shared FSM state type and framing constants for the user-project UART transmitter.
package user_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_MIN_DIV    = 4;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/user_uart_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy count.
module user_uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/user_uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high, fed from a small byte FIFO.
module user_uart_tx
    import user_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic                        enable,
    input  logic [DIV_W-1:0]            clkdiv,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(UART_MIN_DIV);
    localparam logic [2:0]       LAST_BIT = 3'(UART_FRAME_BITS - 3);

    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic             tx_q, tx_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             bit_end;
    logic             launch;
    logic [DIV_W-1:0] div_clamped;

    user_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (resetb),
        .push_i  (in_valid && in_ready),
        .pop_i   (fifo_pop),
        .wdata_i (in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign in_ready    = !fifo_full;
    assign tx          = tx_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign div_clamped = (clkdiv < MIN_DIV) ? MIN_DIV : clkdiv;
    assign bit_end     = (cnt_q == div_q - DIV_W'(1));

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        launch   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                launch = enable && !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    launch  = enable && !fifo_empty;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Frame launch is shared by IDLE and end-of-STOP so back-to-back frames have no gap.
        if (launch) begin
            state_d  = ST_START;
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            div_d    = div_clamped;
            tx_d     = 1'b0;
            cnt_d    = '0;
        end
    end

endmodule
